// File: rtl/coil_guard_pkg.sv
// Shared types and helpers for the coil_guard stepper-output protection block.
package coil_guard_pkg;

  typedef enum logic [2:0] {OFF, RUN, DEAD, SLEEP, FAULT} state_t;

  localparam int A  = 0;
  localparam int B  = 1;
  localparam int AN = 2;
  localparam int BN = 3;

  // Shoot-through: both ends of the same winding energized at once.
  function automatic logic is_illegal(input logic [3:0] p);
    return (p[A] & p[AN]) | (p[B] & p[BN]);
  endfunction

endpackage

// File: rtl/coil_guard_if.sv
// Sequencer-to-driver bus for coil_guard, plus the FSM state for observation.
interface coil_guard_if;
  import coil_guard_pkg::*;

  // No valid/ready here: phase_in and enable are levels sampled on every
  // clock edge, and fault_clr is a single-cycle pulse acted on at that edge.
  logic       enable;
  logic [3:0] phase_in;
  logic       fault_clr;
  logic [3:0] coil;
  logic       fault;
  logic       idle;
  state_t     state;

  modport master (output enable, phase_in, fault_clr,
                  input  coil, fault, idle, state);
  modport slave  (input  enable, phase_in, fault_clr,
                  output coil, fault, idle, state);
endinterface

// File: rtl/coil_dead_timer.sv
// Loadable down-counter; wraps below zero unless SATURATE holds it at zero.
module coil_dead_timer #(
  parameter int W        = 1,
  parameter bit SATURATE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (!(SATURATE && cnt == '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/coil_guard.sv
// Screens sequencer phase patterns, inserts break-before-make dead time,
// latches shoot-through faults and releases the coils after an idle period.
module coil_guard
  import coil_guard_pkg::*;
#(
  parameter int DEAD_CYC     = 4,
  parameter int IDLE_TIMEOUT = 1000000
) (
  input logic         clk,
  input logic         rst,
  coil_guard_if.slave bus
);
  localparam int DW = (DEAD_CYC < 1) ? 1 : $clog2(DEAD_CYC + 1);
  localparam int IW = (IDLE_TIMEOUT < 2) ? 1 : $clog2(IDLE_TIMEOUT);
  // The dead counter ends at zero, so it starts one below the cycle count.
  localparam logic [DW-1:0] DEAD_LOAD = DW'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);
  localparam logic [IW-1:0] IDLE_LOAD = IW'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);

  state_t     state, state_n;
  logic [3:0] applied, applied_n, pending, pending_n, coil_q, coil_n;
  logic [3:0] base, chg_from;
  logic       fault_q, fault_n, idle_q, idle_n;
  logic       chg, dead_load, dead_zero, idle_load, idle_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= OFF;
      applied <= '0;
      pending <= '0;
      coil_q  <= '0;
      fault_q <= 1'b0;
      idle_q  <= 1'b0;
    end else begin
      state   <= state_n;
      applied <= applied_n;
      pending <= pending_n;
      coil_q  <= coil_n;
      fault_q <= fault_n;
      idle_q  <= idle_n;
    end
  end

  always_comb begin
    state_n   = state;
    applied_n = applied;
    pending_n = pending;
    coil_n    = coil_q;
    fault_n   = fault_q;
    idle_n    = idle_q;
    dead_load = 1'b0;
    chg       = 1'b0;
    chg_from  = '0;
    base      = (state == OFF) ? 4'b0000 : applied;

    if (bus.enable && is_illegal(bus.phase_in)) begin
      state_n   = FAULT;
      applied_n = '0;
      pending_n = '0;
      coil_n    = '0;
      fault_n   = 1'b1;
      idle_n    = 1'b0;
    end else if (state == FAULT) begin
      coil_n = '0;
      idle_n = 1'b0;
      if (bus.fault_clr && !is_illegal(bus.phase_in)) begin
        state_n = OFF;
        fault_n = 1'b0;
      end
    end else if (!bus.enable) begin
      state_n   = OFF;
      applied_n = '0;
      pending_n = '0;
      coil_n    = '0;
      idle_n    = 1'b0;
    end else begin
      case (state)
        OFF, RUN: begin
          if (bus.phase_in != base) begin
            chg      = 1'b1;
            chg_from = base;
          end else if (state == RUN && base != 4'b0000 && idle_zero) begin
            state_n = SLEEP;
            coil_n  = '0;
            idle_n  = 1'b1;
          end else begin
            state_n   = RUN;
            applied_n = base;
            coil_n    = base;
          end
        end
        DEAD: begin
          if (bus.phase_in != pending) begin
            chg      = 1'b1;
            chg_from = applied;
          end else if (dead_zero) begin
            state_n   = RUN;
            applied_n = pending;
            coil_n    = pending;
          end else begin
            coil_n = applied & pending;
          end
        end
        SLEEP: begin
          if (bus.phase_in != applied) begin
            chg      = 1'b1;
            chg_from = 4'b0000;
          end
        end
        default: ;
      endcase
    end

    // Any accepted new pattern: drop outgoing bits now, hold incoming ones off.
    if (chg) begin
      idle_n = 1'b0;
      if (DEAD_CYC == 0) begin
        state_n   = RUN;
        applied_n = bus.phase_in;
        coil_n    = bus.phase_in;
      end else begin
        state_n   = DEAD;
        applied_n = chg_from;
        pending_n = bus.phase_in;
        coil_n    = chg_from & bus.phase_in;
        dead_load = 1'b1;
      end
    end
  end

  assign idle_load = (state != RUN) || (state_n != RUN) || (applied_n != applied);

  coil_dead_timer #(.W(DW), .SATURATE(1'b0)) u_dead (
    .clk(clk), .rst(rst), .load(dead_load), .value(DEAD_LOAD), .zero(dead_zero)
  );

  coil_dead_timer #(.W(IW), .SATURATE(1'b1)) u_idle (
    .clk(clk), .rst(rst), .load(idle_load), .value(IDLE_LOAD), .zero(idle_zero)
  );

  assign bus.coil  = coil_q;
  assign bus.fault = fault_q;
  assign bus.idle  = idle_q;
  assign bus.state = state;
endmodule

// File: tb/tb_coil_guard.sv
// Directed bench for coil_guard: per-cycle comparison against a timing model
// plus hand-computed expectations along the main scenarios.
module tb_coil_guard;
  import coil_guard_pkg::*;

  localparam int DEAD = 4;
  localparam int TMO  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  coil_guard_if bus();

  coil_guard #(.DEAD_CYC(DEAD), .IDLE_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  bit armed  = 1'b0;
  logic [15:0] legal_map = 16'h135F;  // bit p set when pattern p is legal

  // ---------------- scoreboard ----------------
  task automatic cmp(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  task automatic lit(input string name, input logic [3:0] c, input logic f, input logic i);
    cmp({name, "_coil"}, bus.coil, c);
    cmp({name, "_fault"}, {3'b000, bus.fault}, {3'b000, f});
    cmp({name, "_idle"}, {3'b000, bus.idle}, {3'b000, i});
  endtask

  // ---------------- behavioural model ----------------
  bit         m_fault, m_sleep;
  logic [3:0] m_applied, m_target;
  int         m_remain, m_age;

  initial begin
    m_fault = 0; m_sleep = 0; m_applied = '0; m_target = '0; m_remain = 0; m_age = 0;
  end

  function automatic logic [3:0] m_coil();
    if (m_fault || m_sleep) return 4'b0000;
    if (m_remain > 0) return m_applied & m_target;
    return m_applied;
  endfunction

  task automatic m_start(input logic [3:0] p);
    if (DEAD == 0) begin
      m_applied = p;
      m_age = 0;
    end else begin
      m_target = p;
      m_remain = DEAD;
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_fault = 0; m_sleep = 0; m_applied = '0; m_target = '0; m_remain = 0; m_age = 0;
    end else if (bus.enable && !legal_map[bus.phase_in]) begin
      m_fault = 1; m_sleep = 0; m_applied = '0; m_target = '0; m_remain = 0; m_age = 0;
    end else if (m_fault) begin
      if (bus.fault_clr && legal_map[bus.phase_in]) m_fault = 0;
    end else if (!bus.enable) begin
      m_sleep = 0; m_applied = '0; m_target = '0; m_remain = 0; m_age = 0;
    end else if (m_remain > 0) begin
      if (bus.phase_in != m_target) begin
        m_target = bus.phase_in;
        m_remain = DEAD;
      end else begin
        m_remain--;
        if (m_remain == 0) begin
          m_applied = m_target;
          m_age = 0;
        end
      end
    end else if (m_sleep) begin
      if (bus.phase_in != m_applied) begin
        m_sleep = 0;
        m_applied = '0;
        m_start(bus.phase_in);
      end
    end else if (bus.phase_in != m_applied) begin
      m_start(bus.phase_in);
    end else if (m_applied != 4'b0000 && m_age == TMO - 1) begin
      m_sleep = 1;
    end else if (m_age < TMO - 1) begin
      m_age++;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      cmp("model_coil", bus.coil, m_coil());
      cmp("model_fault", {3'b000, bus.fault}, {3'b000, m_fault});
      cmp("model_idle", {3'b000, bus.idle}, {3'b000, m_sleep});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic en, input logic [3:0] ph, input logic clr);
    bus.enable    = en;
    bus.phase_in  = ph;
    bus.fault_clr = clr;
    @(posedge clk);
    #1;
  endtask

  // n edges showing the partial pattern, then one edge showing the full one.
  task automatic seq(input string name, input logic [3:0] ph, input int n,
                     input logic [3:0] part, input logic [3:0] full);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, ph, 1'b0);
      lit({name, "_part"}, part, 1'b0, 1'b0);
    end
    drive(1'b1, ph, 1'b0);
    lit({name, "_full"}, full, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.enable = 1'b0; bus.phase_in = 4'b0000; bus.fault_clr = 1'b0;
    rst = 1'b1;
    drive(1'b0, 4'b0000, 1'b0);
    drive(1'b0, 4'b0000, 1'b0);
    rst = 1'b0;
    armed = 1'b1;
    lit("reset", 4'b0000, 1'b0, 1'b0);
    cmp("reset_state", 4'(bus.state), 4'(OFF));

    seq("pwr_on", 4'b0001, 4, 4'b0000, 4'b0001);
    seq("a_ab", 4'b0011, 4, 4'b0001, 4'b0011);
    seq("ab_bc", 4'b0110, 4, 4'b0010, 4'b0110);
    seq("bc_a", 4'b0001, 4, 4'b0000, 4'b0001);

    drive(1'b1, 4'b0011, 1'b0);
    drive(1'b1, 4'b0011, 1'b0);
    lit("redir_pre", 4'b0001, 1'b0, 1'b0);
    seq("redir", 4'b1001, 4, 4'b0001, 4'b1001);

    drive(1'b0, 4'b0101, 1'b0);
    lit("dis_illegal", 4'b0000, 1'b0, 1'b0);
    drive(1'b1, 4'b0101, 1'b0);
    lit("illegal", 4'b0000, 1'b1, 1'b0);
    drive(1'b1, 4'b0101, 1'b1);
    lit("clr_while_bad", 4'b0000, 1'b1, 1'b0);
    drive(1'b1, 4'b0001, 1'b0);
    lit("no_clr", 4'b0000, 1'b1, 1'b0);
    drive(1'b1, 4'b0001, 1'b1);
    lit("clr", 4'b0000, 1'b0, 1'b0);
    cmp("clr_state", 4'(bus.state), 4'(OFF));
    seq("post_clr", 4'b0001, 4, 4'b0000, 4'b0001);

    seq("to_ab", 4'b0011, 4, 4'b0001, 4'b0011);
    for (int i = 0; i < TMO - 1; i++) drive(1'b1, 4'b0011, 1'b0);
    lit("pre_sleep", 4'b0011, 1'b0, 1'b0);
    drive(1'b1, 4'b0011, 1'b0);
    lit("sleep", 4'b0000, 1'b0, 1'b1);
    drive(1'b1, 4'b0011, 1'b0);
    lit("sleep_hold", 4'b0000, 1'b0, 1'b1);
    seq("wake", 4'b0110, 4, 4'b0000, 4'b0110);

    drive(1'b1, 4'b0011, 1'b0);
    drive(1'b1, 4'b0011, 1'b0);
    lit("mid_dead", 4'b0010, 1'b0, 1'b0);
    drive(1'b0, 4'b0011, 1'b0);
    lit("dis_dead", 4'b0000, 1'b0, 1'b0);
    seq("reen", 4'b0011, 4, 4'b0000, 4'b0011);

    rst = 1'b1;
    drive(1'b1, 4'b0011, 1'b0);
    lit("rst_run", 4'b0000, 1'b0, 1'b0);
    cmp("rst_state", 4'(bus.state), 4'(OFF));
    rst = 1'b0;

    for (int p = 0; p < 16; p++) begin
      drive(1'b1, 4'(p), 1'b1);
      cmp("sweep_fault", {3'b000, bus.fault}, {3'b000, ~legal_map[p]});
      repeat (5) drive(1'b1, 4'(p), 1'b0);
    end
    drive(1'b1, 4'b0000, 1'b1);
    drive(1'b1, 4'b0000, 1'b0);

    armed = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/coil_guard.md
Name: coil_guard

Overview:
- Sits directly downstream of the step-sequencer stage and between its 4-bit phase pattern and the motor driver pins.
- Screens each incoming pattern for legality.
- Inserts a break-before-make dead time on every phase change.
- Latches a sticky fault on illegal (shoot-through) patterns.
- De-energizes the coils after a configurable idle period to limit heating.

Parameters:
- DEAD_CYC, 4, clk cycles that newly-energized coils are held off after a phase change (0 allowed).
- IDLE_TIMEOUT, 1000000, cycles with an unchanged, non-zero pattern before the coils are released.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- enable  input  1  1 = drive coils; 0 = force all coils off
- phase_in  input  4  pattern from the sequencer; bit0=A, bit1=B, bit2=A', bit3=B'
- fault_clr  input  1  one-cycle pulse that clears a latched fault
- coil  output  4  registered coil drive, same bit map as phase_in
- fault  output  1  sticky illegal-pattern flag
- idle  output  1  1 while coils are released by the idle timeout

Behaviour:
- Reset (one clk edge with rst=1): coil=0000, fault=0, idle=0, state=OFF, applied=0000, pending=0000, counters=0. All outputs are registered.
- Legal patterns: 0000, the one-hot patterns, and the adjacent pairs 0011/0110/1100/1001.
- Illegal pattern: (bit0&bit2) | (bit1&bit3).
- States:
  - OFF: coil=0. Entered when enable=0 from any state except FAULT, or on exit from reset. With enable=1, behaves as RUN with applied=0000.
  - RUN: coil=applied. If phase_in≠applied and is legal: pending<=phase_in, dead counter<=DEAD_CYC, go to DEAD. If DEAD_CYC=0, go straight to applied<=phase_in.
  - DEAD: coil = applied & pending, so bits turning off drop immediately and bits turning on wait.
    - Counter decrements each cycle; at 0: applied<=pending, go to RUN.
    - If phase_in changes to a different legal value during DEAD: compute coil from applied & new, set pending<=new, and reload the counter.
  - SLEEP: coil=0000, idle=1.
    - Entered from RUN when applied≠0000 and the idle counter reaches IDLE_TIMEOUT-1.
    - A legal phase_in≠applied sets applied<=0000, then follows the DEAD path; idle drops on the same edge.
  - FAULT: entered on any edge where enable=1 and phase_in is illegal, from any state.
    - coil=0000, fault=1, applied<=0000.
    - Exits to OFF on the fault_clr edge only if the current phase_in is legal. Otherwise it stays in FAULT.
- Timing: phase_in sampled at edge k →
  - partial pattern on coil from edge k+1 to k+DEAD_CYC;
  - full pattern from edge k+DEAD_CYC+1.
- Idle counter: resets on any change of applied or on leaving RUN, and saturates at IDLE_TIMEOUT-1. Its width is $clog2(IDLE_TIMEOUT).
- Dead counter width: $clog2(DEAD_CYC+1), minimum 1 bit.
- Simultaneous-event priority (highest first): rst > illegal pattern > enable=0 > fault_clr > pattern change > timeouts.
- enable falling mid-DEAD: coil=0000 on the next edge and the pending pattern is discarded.
- rst asserted in any state returns every output to its reset value on that edge.
- When enable=0, an illegal pattern is ignored (no fault).

Decomposition:
- Package coil_guard_pkg:
  - state enum {OFF, RUN, DEAD, SLEEP, FAULT};
  - bit-index constants A/B/AN/BN;
  - function is_illegal(logic[3:0]).
- Sub-module coil_dead_timer: loadable down-counter with load and value inputs and a zero output. It is instantiated once for the dead time, and once with saturate mode for the idle counter.

Test Plan (DEAD_CYC=4, IDLE_TIMEOUT=16):
- Reset, then enable=1 with phase_in=0001 → coil=0000 for edges 1-4, 0001 at edge 5. fault=0, idle=0.
- From applied 0001, phase_in=0011 → coil stays 0001 for 4 cycles, then 0011. From 0011, phase_in=0110 → coil=0010 for 4 cycles, then 0110.
- In DEAD (0001→0011), after 2 cycles change to 1001 → coil=0001, counter reloads, and 1001 appears 5 edges after the change.
- phase_in=0101 with enable=1 → next edge coil=0000, fault=1. A fault_clr pulse while still 0101 keeps fault=1. Set phase_in=0001, pulse fault_clr → fault=0 and state OFF; 0001 is then applied after the dead time.
- Hold 0011 steady for 16 cycles → coil=0000, idle=1. Apply 0110 → idle=0, coil=0000 for 4 cycles, then 0110.
- enable=0 mid-DEAD → coil=0000 next edge. Re-enable with the same pattern → full dead-time sequence from 0000. Assert rst mid-RUN → all outputs zero on that edge.
